// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory port arbiter: arbitration states and
// the full byte-enable constant used for instruction fetches.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_BE_W   = PIPE_DATA_W / 8;

    localparam logic [PIPE_BE_W-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        FETCH_DROP
    } arb_state_t;

endpackage

// File: rtl/arb_ibuf.sv
// Instruction buffer: holds the last fetched word until the fetch stage
// consumes it or a redirect discards it.
module arb_ibuf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_D,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              take,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              valid
);

    // A redirect beats a same-cycle fill; take only matters once a word is held.
    always_ff @(posedge clk or posedge reset_D) begin
        if (reset_D) begin
            valid <= 1'b0;
            rdata <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            rdata <= fill_data;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and the memory stage; data accesses win because they belong to the older instruction.
module mem_port_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic                clk,
    input  logic                reset_D,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_take,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] FETCH_BE = {BE_W{1'b1}};

    arb_state_t state, state_nxt;

    logic              req_nxt;
    logic              we_nxt;
    logic [BE_W-1:0]   be_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              done_nxt;
    logic              load_en;
    logic              fill;
    logic              ack;

    // An ack only counts while a request is actually on the bus.
    assign ack = mem_ack & mem_req;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        be_nxt    = mem_be;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        done_nxt  = 1'b0;
        load_en   = 1'b0;
        fill      = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && !d_done) begin
                    state_nxt = DATA;
                    req_nxt   = 1'b1;
                    we_nxt    = d_we;
                    be_nxt    = d_be;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                end else if (if_req && !if_valid && !if_flush) begin
                    state_nxt = FETCH;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    be_nxt    = FETCH_BE;
                    addr_nxt  = if_addr;
                    wdata_nxt = '0;
                end
            end
            DATA: begin
                if (ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    load_en   = !mem_we;
                end
            end
            FETCH: begin
                if (ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    fill      = !if_flush;
                end else if (if_flush) begin
                    state_nxt = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                // The access already issued must finish; its data is thrown away.
                if (ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset_D) begin
        if (reset_D) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_be    <= be_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            d_done    <= done_nxt;
            if (load_en) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    arb_ibuf #(
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk       (clk),
        .reset_D   (reset_D),
        .fill      (fill),
        .fill_data (mem_rdata),
        .take      (if_take),
        .flush     (if_flush),
        .rdata     (if_rdata),
        .valid     (if_valid)
    );

    // d_done doubles as the memory stage's advance qualifier, so it releases the stall.
    assign stall_mem = d_req & ~d_done;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table vectors, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset_D = 1'b1;
    logic        if_req, if_take, if_flush;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_done, stall_if, stall_mem;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset_D   (reset_D),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_take   (if_take),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // The fetch address may only move while nothing is buffered or under a redirect.
    logic        last_valid = 1'b0;
    logic [31:0] last_addr = 32'h0;
    always @(posedge clk) begin
        if (!reset_D && last_valid && if_valid && !if_flush && if_addr !== last_addr)
            $error("illegal if_addr change while an instruction is buffered");
        last_valid <= if_valid && !reset_D;
        last_addr  <= if_addr;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_check(input string name, input logic req, input logic we,
                             input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        check(name, {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {req, we, be, addr, wdata});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves if_addr alone so a buffered instruction never sees its address move.
    task automatic idle_inputs();
        if_req = 1'b0; if_take = 1'b0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_D = 1'b1;
        @(negedge clk);
        reset_D = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        d_req, d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic        if_req, if_flush;
        logic [31:0] if_addr;
        logic        exp_stall_if, exp_stall_mem, exp_req, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    // Transaction-level reference: the access currently owning the port, plus
    // the values the pipeline should see.
    bit          m_busy, m_data, m_drop, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    bit          m_done, m_ivalid;
    logic [31:0] m_drdata, m_irdata;

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_drop = 0; m_we = 0; m_be = 4'h0;
        m_addr = 32'h0; m_wdata = 32'h0; m_done = 0; m_ivalid = 0;
        m_drdata = 32'h0; m_irdata = 32'h0;
    endtask

    task automatic model_edge();
        bit was_busy, acked, fill, new_done;
        was_busy = m_busy;
        acked    = m_busy && mem_ack;
        fill     = 0;
        new_done = acked && m_data;
        if (acked) begin
            if (m_data && !m_we) m_drdata = mem_rdata;
            if (!m_data && !m_drop && !if_flush) fill = 1;
            m_busy = 0;
        end else if (m_busy && !m_data && if_flush) begin
            m_drop = 1;
        end
        if (!was_busy) begin
            if (d_req && !m_done) begin
                m_busy = 1; m_data = 1; m_drop = 0;
                m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
            end else if (if_req && !m_ivalid && !if_flush) begin
                m_busy = 1; m_data = 0; m_drop = 0;
                m_we = 0; m_be = BE_ALL; m_addr = if_addr; m_wdata = 32'h0;
            end
        end
        m_done = new_done;
        if (if_flush) m_ivalid = 0;
        else if (fill) begin m_ivalid = 1; m_irdata = mem_rdata; end
        else if (if_take) m_ivalid = 0;
    endtask

    initial begin
        int          wait_cnt;
        bit          prev_req, prev_ack, take_prev, d_pend;
        logic [31:0] pc;

        // Reset values, checked while reset is held.
        idle_inputs();
        #3;
        bus_check("reset_bus", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("reset_flags", {d_done, if_valid, stall_if, stall_mem}, 4'b0000);
        check("reset_rdata", {d_rdata, if_rdata}, 64'h0);
        @(negedge clk);
        reset_D = 1'b0;
        tick();

        // Single-cycle vectors from an idle port with an empty instruction buffer.
        // Fields: d_req d_we d_be d_addr | if_req if_flush if_addr | stall_if stall_mem req we be addr
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h400};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h500, 1'b0, 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h500};
        vecs[3] = '{1'b1, 1'b1, 4'hC, 32'h600, 1'b1, 1'b0, 32'h700, 1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 32'h600};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b1, 32'h740, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'h5, 32'h800, 1'b1, 1'b1, 32'h780, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 32'h800};
        for (int i = 0; i < 6; i++) begin
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be; d_addr = vecs[i].d_addr;
            d_wdata = 32'h0;
            if_req = vecs[i].if_req; if_flush = vecs[i].if_flush; if_addr = vecs[i].if_addr;
            #1;
            check($sformatf("tv%0d_stalls", i), {stall_if, stall_mem}, {vecs[i].exp_stall_if, vecs[i].exp_stall_mem});
            tick();
            check($sformatf("tv%0d_req", i), mem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                check($sformatf("tv%0d_bus", i), {mem_we, mem_be, mem_addr},
                      {vecs[i].exp_we, vecs[i].exp_be, vecs[i].exp_addr});
                mem_ack = 1'b1;
                tick();
            end
            idle_inputs();
            if_take = 1'b1;
            tick();
            if_take = 1'b0;
            tick();
        end

        // Zero-wait fetch.
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h10;
        #1 check("f0_stall_if_wait", stall_if, 1'b1);
        tick();
        bus_check("f0_grant", 1'b1, 1'b0, BE_ALL, 32'h10, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("f0_if_valid", if_valid, 1'b1);
        check("f0_if_rdata", if_rdata, 32'h00500093);
        check("f0_mem_req_drop", mem_req, 1'b0);
        #1 check("f0_stall_if_clear", stall_if, 1'b0);
        tick();
        check("f0_hold", {if_valid, mem_req}, 2'b10);
        if_take = 1'b1;
        tick();
        if_take = 1'b0; if_req = 1'b0;
        check("f0_take", if_valid, 1'b0);

        // Contention: load wins, 3-cycle memory, fetch follows.
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        #1 check("c_stalls", {stall_if, stall_mem}, 2'b11);
        tick();
        bus_check("c_data_first", 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus_check("c_hold", 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            check("c_stall_if", stall_if, 1'b1);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        tick();
        mem_ack = 1'b0;
        check("c_done", {d_done, mem_req}, 2'b10);
        check("c_rdata", d_rdata, 32'hCAFE0001);
        #1 check("c_stalls_done", {stall_if, stall_mem}, 2'b10);
        tick();
        check("c_done_pulse", d_done, 1'b0);
        bus_check("c_fetch_next", 1'b1, 1'b0, BE_ALL, 32'h20, 32'h0);
        d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h00A00113;
        tick();
        mem_ack = 1'b0;
        check("c_fetch_fill", {if_valid, if_rdata}, {1'b1, 32'h00A00113});
        if_take = 1'b1; if_req = 1'b0;
        tick();
        if_take = 1'b0;

        // Store with byte enables over a 3-cycle access.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h204;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_check("s_bus", 1'b1, 1'b1, 4'b0011, 32'h204, 32'hDEADBEEF);
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h12345678; end
            tick();
        end
        mem_ack = 1'b0;
        check("s_done", d_done, 1'b1);
        check("s_rdata_kept", d_rdata, 32'hCAFE0001);
        d_req = 1'b0;
        tick();
        check("s_done_pulse", {d_done, mem_req}, 2'b00);

        // Redirect during the second wait cycle of a 4-cycle fetch.
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        bus_check("fl_grant", 1'b1, 1'b0, BE_ALL, 32'h40, 32'h0);
        tick();
        if_flush = 1'b1; if_addr = 32'h80;
        tick();
        if_flush = 1'b0;
        bus_check("fl_hold", 1'b1, 1'b0, BE_ALL, 32'h40, 32'h0);
        tick();
        check("fl_no_valid", if_valid, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        check("fl_discard", {if_valid, mem_req}, 2'b00);
        tick();
        bus_check("fl_refetch", 1'b1, 1'b0, BE_ALL, 32'h80, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        tick();
        mem_ack = 1'b0;
        check("fl_fill", {if_valid, if_rdata}, {1'b1, 32'h22222222});
        if_take = 1'b1; if_req = 1'b0;
        tick();
        if_take = 1'b0;

        // Redirect in the same cycle as the fetch ack.
        if_req = 1'b1; if_addr = 32'h90;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h33333333; if_flush = 1'b1; if_addr = 32'hA0;
        tick();
        mem_ack = 1'b0; if_flush = 1'b0;
        check("fa_discard", {if_valid, mem_req}, 2'b00);
        tick();
        bus_check("fa_refetch", 1'b1, 1'b0, BE_ALL, 32'hA0, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h44444444;
        tick();
        mem_ack = 1'b0;
        check("fa_fill", {if_valid, if_rdata}, {1'b1, 32'h44444444});
        if_take = 1'b1; if_req = 1'b0;
        tick();
        if_take = 1'b0;

        // Asynchronous reset while a load waits on memory.
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h0;
        tick();
        check("r_req_before", mem_req, 1'b1);
        #2 reset_D = 1'b1;
        #1 check("r_async", {mem_req, d_done, if_valid}, 3'b000);
        d_addr = 32'h304;
        @(negedge clk);
        reset_D = 1'b0;
        tick();
        bus_check("r_first_grant", 1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        check("r_done", {d_done, d_rdata}, {1'b1, 32'h55555555});
        d_req = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        wait_cnt = 0; prev_req = 0; prev_ack = 0; take_prev = 0; d_pend = 0;
        pc = 32'h1000;
        if_addr = pc;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_mem_req", mem_req, m_busy);
            if (m_busy) bus_check("rnd_bus", 1'b1, m_we, m_be, m_addr, m_wdata);
            check("rnd_d_done", d_done, m_done);
            check("rnd_d_rdata", d_rdata, m_drdata);
            check("rnd_if_valid", if_valid, m_ivalid);
            if (m_ivalid) check("rnd_if_rdata", if_rdata, m_irdata);

            if_flush = ($urandom_range(0, 11) == 0);
            if (if_flush) pc = $urandom & 32'h0000FFFC;
            else if (take_prev) pc = pc + 32'd4;
            if_addr = pc;
            if_req  = ($urandom_range(0, 4) != 0);
            if_take = m_ivalid && ($urandom_range(0, 1) == 1);
            take_prev = if_take && !if_flush;

            if (d_done) begin
                d_pend = ($urandom_range(0, 2) == 0);
            end else if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend  = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom);
                d_addr  = $urandom & 32'hFFFFFFFC;
                d_wdata = $urandom;
            end
            d_req = d_pend;

            if (mem_req) begin
                if (!prev_req || prev_ack) wait_cnt = $urandom_range(0, 3);
                else wait_cnt--;
                mem_ack = (wait_cnt == 0);
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
            mem_rdata = $urandom;
            prev_req  = mem_req;
            prev_ack  = mem_ack && mem_req;

            #1;
            check("rnd_stall_mem", stall_mem, d_req && !m_done);
            check("rnd_stall_if", stall_if, (if_req && !m_ivalid) || (d_req && !m_done));
            model_edge();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
